// File: rtl/sync_arb.sv
// Round-robin arbiter driving the 4-phase v/ack channel of sync_multi; grant registered one edge after req.
// No timeout: the channel holds in SEND/REL until ch_ack moves, and requesters wait for done.
module sync_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REQ      = 4,
   parameter int ID_W       = 3
) (
   input  logic                        clk1,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]       ch_data,
   output logic                        ch_v,
   input  logic                        ch_ack,
   output logic                        busy,
   output logic [ID_W-1:0]             gnt_id,
   output logic [15:0]                 xfer_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, REL} state_t;

   state_t                  state, state_nxt;
   logic [ID_W-1:0]         ptr, ptr_nxt;
   logic                    ch_v_nxt;
   logic [DATA_WIDTH-1:0]   ch_data_nxt;
   logic [N_REQ-1:0]        done_nxt;
   logic                    busy_nxt;
   logic [ID_W-1:0]         gnt_id_nxt;
   logic [15:0]             xfer_cnt_nxt;

   logic [2*N_REQ-1:0]      req_rot;
   logic                    win_vld;
   int                      win_off;
   int                      win_sum;
   logic [ID_W-1:0]         win_id;
   logic [DATA_WIDTH-1:0]   win_dat;

   // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
   always_comb begin
      req_rot = {req, req} >> ptr;
      win_vld = |req;
      win_off = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) win_off = i;
      end
      win_sum = win_off + int'(ptr);
      if (win_sum >= N_REQ) win_sum = win_sum - N_REQ;
      win_id  = ID_W'(win_sum);
      win_dat = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == win_id) win_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      ch_v_nxt     = ch_v;
      ch_data_nxt  = ch_data;
      done_nxt     = '0;
      busy_nxt     = busy;
      gnt_id_nxt   = gnt_id;
      xfer_cnt_nxt = xfer_cnt;
      case (state)
         IDLE: begin
            if (win_vld) begin
               ch_data_nxt = win_dat;
               gnt_id_nxt  = win_id;
               ch_v_nxt    = 1'b1;
               busy_nxt    = 1'b1;
               state_nxt   = SEND;
            end
         end
         SEND: begin
            if (ch_ack) begin
               ch_v_nxt  = 1'b0;
               done_nxt  = N_REQ'(1) << gnt_id;
               state_nxt = REL;
            end
         end
         REL: begin
            // Pointer advances only once the handshake fully closes.
            if (!ch_ack) begin
               ptr_nxt      = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
               xfer_cnt_nxt = xfer_cnt + 16'd1;
               busy_nxt     = 1'b0;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         ch_v     <= 1'b0;
         ch_data  <= '0;
         done     <= '0;
         busy     <= 1'b0;
         gnt_id   <= '0;
         xfer_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         ch_v     <= ch_v_nxt;
         ch_data  <= ch_data_nxt;
         done     <= done_nxt;
         busy     <= busy_nxt;
         gnt_id   <= gnt_id_nxt;
         xfer_cnt <= xfer_cnt_nxt;
      end
   end

endmodule
